// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - radix-2 restoring DIV/DIVU sequencer beside EXE; holds HI/LO results.
// Optional DIV_EARLY_EXIT_EN: skip the shift loop when |dividend| < |divisor|.
module div_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_req,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              div_busy,
  output logic              div_done,
  output logic              hilo_we,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] part_r;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W-1:0] quo_sh;
  logic [DATA_W-1:0] dividend_q;
  logic [CNT_W-1:0]  counter;
  logic              sign_q;
  logic              sign_r;
  logic              div_by_zero;
  logic              early;

  logic [DATA_W-1:0] abs_dividend;
  logic [DATA_W-1:0] abs_divisor;
  logic [DATA_W:0]   trial;
  logic              take;
  logic [DATA_W-1:0] next_p;
  logic              early_exit;

  assign abs_dividend = (div_signed && dividend[DATA_W-1]) ? -dividend : dividend;
  assign abs_divisor  = (div_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

  // Trial value keeps one extra bit: 2*P+1 can exceed DATA_W bits when |divisor| > 2^(DATA_W-1).
  assign trial  = {part_r, acc_a[DATA_W-1]};
  assign take   = (trial >= {1'b0, abs_b});
  assign next_p = take ? (trial[DATA_W-1:0] - abs_b) : trial[DATA_W-1:0];

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (abs_dividend < abs_divisor) && (divisor != '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_busy    <= 1'b0;
      div_done    <= 1'b0;
      hilo_we     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      counter     <= '0;
      acc_a       <= '0;
      part_r      <= '0;
      abs_b       <= '0;
      quo_sh      <= '0;
      dividend_q  <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div_by_zero <= 1'b0;
      early       <= 1'b0;
    end else if (cancel) begin
      state    <= IDLE;
      div_busy <= 1'b0;
      div_done <= 1'b0;
      hilo_we  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          div_done <= 1'b0;
          hilo_we  <= 1'b0;
          if (div_req) begin
            acc_a       <= abs_dividend;
            abs_b       <= abs_divisor;
            part_r      <= '0;
            quo_sh      <= '0;
            dividend_q  <= dividend;
            sign_q      <= div_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            sign_r      <= div_signed & dividend[DATA_W-1];
            div_by_zero <= (divisor == '0);
            early       <= early_exit;
            counter     <= CNT_W'(DATA_W - 1);
            div_busy    <= 1'b1;
            state       <= early_exit ? FIX : RUN;
          end else begin
            div_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        RUN: begin
          acc_a  <= {acc_a[DATA_W-2:0], 1'b0};
          part_r <= next_p;
          quo_sh <= {quo_sh[DATA_W-2:0], take};
          if (counter == '0) begin
            state <= FIX;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        FIX: begin
          // Divide-by-zero bypasses sign fixup: the loop leaves |dividend| in P.
          if (div_by_zero) begin
            quotient  <= '1;
            remainder <= dividend_q;
          end else if (early) begin
            quotient  <= '0;
            remainder <= dividend_q;
          end else begin
            quotient  <= sign_q ? -quo_sh : quo_sh;
            remainder <= sign_r ? -part_r : part_r;
          end
          div_busy <= 1'b0;
          div_done <= 1'b1;
          hilo_we  <= 1'b1;
          state    <= DONE;
        end
        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
          div_done <= 1'b0;
          hilo_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative divide controller for DIV/DIVU in the 5-stage pipeline. It sits beside the EXE stage.
- Accepts one divide request and runs a radix-2 restoring division, one quotient bit per cycle.
- Drives `div_busy` into the bypass/hazard unit, which stalls a following divide in ID.
- Delivers quotient/remainder with a one-cycle HI/LO write strobe.

Parameters:
- DATA_W, 32, operand/result width; counter width is clog2(DATA_W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- div_req  in  1  start request from EXE (DIV or DIVU decoded, instruction valid)
- div_signed  in  1  1=DIV (two's complement), 0=DIVU; sampled with div_req
- dividend  in  DATA_W  rs value; sampled with div_req
- divisor  in  DATA_W  rt value; sampled with div_req
- cancel  in  1  pipeline flush (exception/eret); aborts operation
- div_busy  out  1  divide in progress (RUN or FIX)
- div_done  out  1  one-cycle pulse, results valid
- hilo_we  out  1  HI/LO write enable, equal to div_done
- quotient  out  DATA_W  LO value
- remainder  out  DATA_W  HI value

Behaviour:
- States: IDLE, RUN, FIX, DONE.
- Reset: state=IDLE; div_busy=0, div_done=0, hilo_we=0, quotient=0, remainder=0, counter=0.
- Accept rule: div_req sampled high while state is IDLE or DONE, with cancel=0.
  - Latch sign flags, |dividend|, |divisor|, and div_by_zero = (divisor==0).
  - Go to RUN with counter=DATA_W-1.
  - For the unsigned path, abs is identity.
- Sign of operands (signed op only): sign_q = sign(dividend) XOR sign(divisor); sign_r = sign(dividend).
- RUN: each cycle, partial remainder P = {P[DATA_W-2:0], A[MSB]}; A shifts left.
  - If P >= |divisor|: P -= |divisor| and shift 1 into the quotient LSB; else shift 0.
  - When counter==0, go to FIX; else decrement.
  - RUN lasts exactly DATA_W cycles.
- FIX (1 cycle): negate the quotient if sign_q, negate the remainder if sign_r. Go to DONE.
- DONE (1 cycle): div_done=1, hilo_we=1; quotient/remainder registers updated at FIX→DONE edge.
  - Next state is RUN if a new request is accepted, else IDLE.
- Latency: request sampled at edge t.
  - div_busy=1 for cycles t+1 … t+DATA_W+1.
  - div_done=1 in cycle t+DATA_W+2 (t+34 for DATA_W=32).
- quotient/remainder hold their value until the next DONE; they do not change during RUN.
- Divide by zero, any signedness: quotient=all ones, remainder=dividend as supplied. Same latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0. No trap.
- div_req while RUN/FIX: ignored, with no effect on the running operation. The hazard unit guarantees no such request in normal operation.
- cancel: when high in any state, next state is IDLE; div_done/hilo_we stay 0; quotient/remainder keep previous values.
  - cancel together with div_req: cancel wins and the request is dropped.
  - cancel sampled in the DONE cycle does not suppress that cycle's already-asserted pulse.
- Reset mid-operation: returns to the reset state next cycle, no done pulse.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN
- Defined: at accept, if |dividend| < |divisor| and divisor != 0, skip RUN and go directly to FIX.
  - FIX sets quotient=0 and remainder=dividend as supplied.
  - div_busy high 1 cycle; div_done at t+2.
- Not defined: every operation takes the full DATA_W+2 latency. The early-exit compare logic is absent.

Test Plan:
- DIVU 100/7, req at t → div_busy t+1..t+33, div_done/hilo_we at t+34; quotient=14, remainder=2.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF at t+34. Also DIV 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- DIVU 0x1234/0 → quotient=0xFFFFFFFF, remainder=0x1234 at t+34. DIV 0xFFFFFFF0/0 → quotient=0xFFFFFFFF, remainder=0xFFFFFFF0.
- Start 100/7, assert cancel at t+10 → IDLE at t+11, no done pulse.
  - quotient/remainder retain prior values.
  - div_req with cancel in the same IDLE cycle → not accepted, div_busy stays 0.
- Back-to-back: second req (50/5) held high in the DONE cycle of the first → first result 14/2 pulses at t+34; second done at t+68 with quotient=10, remainder=0; div_busy low only during DONE cycles.
- DIVU 5/9 → with DIV_EARLY_EXIT_EN: div_done at t+2, quotient=0, remainder=5; without: same result at t+34.
